// File: rtl/oam_dma_ctrl_pkg.sv
// Shared PPU definitions: OAM DMA state encoding, sizes, echo-page mapping
// and the PPU mode/register layouts used alongside it.
package oam_dma_ctrl_pkg;

    localparam int unsigned OAM_BYTES        = 160;
    localparam int unsigned DMA_STEP_DIV     = 4;
    localparam logic [7:0]  ECHO_PAGE_BASE   = 8'hE0;
    localparam logic [7:0]  ECHO_PAGE_OFFSET = 8'h20;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_ARM  = 2'd1,
        DMA_XFER = 2'd2
    } dma_state_t;

    typedef enum logic [1:0] {
        PPU_HBLANK   = 2'd0,
        PPU_VBLANK   = 2'd1,
        PPU_OAM_SCAN = 2'd2,
        PPU_DRAW     = 2'd3
    } ppu_phase_t;

    typedef struct packed {
        logic lcd_on;
        logic win_map;
        logic win_on;
        logic tile_data;
        logic bg_map;
        logic obj_size;
        logic obj_on;
        logic bg_on;
    } ppu_lcdc_t;

    typedef struct packed {
        logic       pad;
        logic       lyc_int;
        logic       oam_int;
        logic       vblank_int;
        logic       hblank_int;
        logic       lyc_match;
        ppu_phase_t mode;
    } ppu_stat_t;

    // Pages 0xE0..0xFF mirror work RAM at 0xC0..0xDF.
    function automatic logic [7:0] dma_eff_page(input logic [7:0] page);
        return (page >= ECHO_PAGE_BASE) ? 8'(page - ECHO_PAGE_OFFSET) : page;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU register, source bus and OAM write port of the OAM DMA engine.
interface oam_dma_ctrl_if;
    logic        start;
    logic [7:0]  src_page;
    logic [7:0]  reg_d_rd;
    logic [15:0] dma_src_addr;
    logic        dma_rd;
    logic [7:0]  dma_d_in;
    logic        dma_active;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_d_wr;
    logic        oam_write;

    modport master (
        input  start, src_page, dma_d_in,
        output reg_d_rd, dma_src_addr, dma_rd, dma_active,
               oam_addr, oam_d_wr, oam_write
    );

    modport slave (
        output start, src_page, dma_d_in,
        input  reg_d_rd, dma_src_addr, dma_rd, dma_active,
               oam_addr, oam_d_wr, oam_write
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: copies BYTES bytes from page src_page into OAM, one byte
// every STEP_DIV clocks, after a STEP_DIV-clock arming delay.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int unsigned BYTES    = OAM_BYTES,
    parameter int unsigned STEP_DIV = DMA_STEP_DIV
) (
    input  logic          clk,
    input  logic          rst,
    oam_dma_ctrl_if.master bus
);

    localparam int unsigned PH_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(STEP_DIV - 1);
    localparam logic [PH_W-1:0] PH_WRITE = PH_W'(1);
    localparam logic [7:0]      IDX_LAST = 8'(BYTES - 1);

    dma_state_t      state;
    logic [PH_W-1:0] ph;
    logic [7:0]      idx;
    logic [7:0]      page;
    logic [7:0]      reg_page;
    logic            arm_restart;

    logic            xfer_slot;
    logic            rd_now;
    logic            wr_now;

    // Sequencer: a CPU write restarts from any state; otherwise step phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DMA_IDLE;
            ph          <= '0;
            idx         <= '0;
            page        <= '0;
            reg_page    <= '0;
            arm_restart <= 1'b0;
        end else if (bus.start) begin
            state       <= DMA_ARM;
            ph          <= '0;
            idx         <= '0;
            page        <= bus.src_page;
            reg_page    <= bus.src_page;
            arm_restart <= (state == DMA_XFER);
        end else begin
            case (state)
                DMA_IDLE: begin
                    ph  <= '0;
                    idx <= '0;
                end
                DMA_ARM: begin
                    if (ph == PH_LAST) begin
                        state <= DMA_XFER;
                        ph    <= '0;
                        idx   <= '0;
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                DMA_XFER: begin
                    if (ph == PH_LAST) begin
                        ph <= '0;
                        if (idx == IDX_LAST) begin
                            state       <= DMA_IDLE;
                            idx         <= '0;
                            arm_restart <= 1'b0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                default: begin
                    state <= DMA_IDLE;
                    ph    <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Bus strobes decode straight from state/ph/idx; a pending start kills them.
    always_comb begin
        xfer_slot        = (state == DMA_XFER) && !bus.start;
        rd_now           = xfer_slot && (ph == '0);
        wr_now           = xfer_slot && (ph == PH_WRITE);

        bus.dma_rd       = rd_now;
        bus.dma_src_addr = rd_now ? {dma_eff_page(page), idx} : 16'h0000;
        bus.oam_write    = wr_now;
        bus.oam_addr     = wr_now ? idx : 8'h00;
        bus.oam_d_wr     = wr_now ? bus.dma_d_in : 8'h00;
        bus.dma_active   = (state == DMA_XFER) || ((state == DMA_ARM) && arm_restart);
    end

    assign bus.reg_d_rd = reg_page;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: default 160-byte/4-clock instance plus a
// 4-byte/2-clock instance, fed from a synchronous RAM model.
module tb_oam_dma_ctrl;

    localparam int unsigned LOG_N = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oam_dma_ctrl_if bus_a ();
    oam_dma_ctrl_if bus_b ();

    oam_dma_ctrl #(.BYTES(160), .STEP_DIV(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    oam_dma_ctrl #(.BYTES(4),   .STEP_DIV(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    // Synchronous source RAM: data appears one clock after the read strobe.
    always @(posedge clk) begin
        bus_a.dma_d_in <= bus_a.dma_rd ? mem_byte(bus_a.dma_src_addr) : 8'h00;
        bus_b.dma_d_in <= bus_b.dma_rd ? mem_byte(bus_b.dma_src_addr) : 8'h00;
    end

    logic [7:0]  wa_addr [LOG_N];
    logic [7:0]  wa_data [LOG_N];
    int unsigned wa_cyc  [LOG_N];
    logic [15:0] ra_addr [LOG_N];
    int unsigned wa_n = 0, ra_n = 0, act_a = 0, rise_a = 0, fall_a = 0, rise_cyc_a = 0;
    logic        prev_a = 1'b0;

    logic [7:0]  wb_addr [LOG_N];
    logic [7:0]  wb_data [LOG_N];
    int unsigned wb_cyc  [LOG_N];
    int unsigned wb_n = 0, act_b = 0, fall_b = 0, rise_cyc_b = 0;
    logic        prev_b = 1'b0;

    // Mid-cycle monitors logging OAM writes, source reads and dma_active edges.
    always @(negedge clk) begin
        if (bus_a.oam_write && wa_n < LOG_N) begin
            wa_addr[wa_n] = bus_a.oam_addr;
            wa_data[wa_n] = bus_a.oam_d_wr;
            wa_cyc[wa_n]  = cyc;
            wa_n++;
        end
        if (bus_a.dma_rd && ra_n < LOG_N) begin
            ra_addr[ra_n] = bus_a.dma_src_addr;
            ra_n++;
        end
        if (bus_a.dma_active) act_a++;
        if (bus_a.dma_active && !prev_a) begin
            rise_a++;
            rise_cyc_a = cyc;
        end
        if (!bus_a.dma_active && prev_a) fall_a++;
        prev_a = bus_a.dma_active;

        if (bus_b.oam_write && wb_n < LOG_N) begin
            wb_addr[wb_n] = bus_b.oam_addr;
            wb_data[wb_n] = bus_b.oam_d_wr;
            wb_cyc[wb_n]  = cyc;
            wb_n++;
        end
        if (bus_b.dma_active) act_b++;
        if (bus_b.dma_active && !prev_b) rise_cyc_b = cyc;
        if (!bus_b.dma_active && prev_b) fall_b++;
        prev_b = bus_b.dma_active;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_a(input logic [7:0] p, output int unsigned s);
        @(posedge clk); #1;
        bus_a.start    = 1'b1;
        bus_a.src_page = p;
        s = cyc + 1;
        @(posedge clk); #1;
        bus_a.start    = 1'b0;
    endtask

    task automatic pulse_b(input logic [7:0] p, output int unsigned s);
        @(posedge clk); #1;
        bus_b.start    = 1'b1;
        bus_b.src_page = p;
        s = cyc + 1;
        @(posedge clk); #1;
        bus_b.start    = 1'b0;
    endtask

    task automatic wait_fall_a(input int unsigned base, input string tag);
        int unsigned n = 0;
        while (fall_a == base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 32'(fall_a - base), 32'd1);
    endtask

    task automatic wait_fall_b(input int unsigned base, input string tag);
        int unsigned n = 0;
        while (fall_b == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 32'(fall_b - base), 32'd1);
    endtask

    task automatic wait_rd_a(input logic [15:0] addr, input string tag);
        int unsigned n   = 0;
        bit          hit = 1'b0;
        while (!hit && n < 3000) begin
            @(negedge clk);
            n++;
            hit = bus_a.dma_rd && (bus_a.dma_src_addr == addr);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_active"},   32'(bus_a.dma_active),   32'd0);
        check({tag, "_rd"},       32'(bus_a.dma_rd),       32'd0);
        check({tag, "_src_addr"}, 32'(bus_a.dma_src_addr), 32'd0);
        check({tag, "_write"},    32'(bus_a.oam_write),    32'd0);
        check({tag, "_oam_addr"}, 32'(bus_a.oam_addr),     32'd0);
        check({tag, "_oam_data"}, 32'(bus_a.oam_d_wr),     32'd0);
        check({tag, "_reg_rd"},   32'(bus_a.reg_d_rd),     32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s, wb, rb, ab, fb, rsb;
        bus_a.start = 1'b0; bus_a.src_page = 8'h00;
        bus_b.start = 1'b0; bus_b.src_page = 8'h00;

        // Async reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_all_zero_a("reset");
        check("reset_b_active", 32'(bus_b.dma_active), 32'd0);
        check("reset_b_reg_rd", 32'(bus_b.reg_d_rd),   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_active", 32'(bus_a.dma_active), 32'd0);
        check("idle_rd",     32'(bus_a.dma_rd),     32'd0);

        // Basic transfer from 0xC100.
        wb = wa_n; rb = ra_n; ab = act_a; fb = fall_a;
        pulse_a(8'hC1, s);
        @(negedge clk);
        check("basic_reg_rd",    32'(bus_a.reg_d_rd),   32'h00C1);
        check("basic_arm_quiet", 32'(bus_a.dma_active), 32'd0);
        wait_fall_a(fb, "basic_done");
        check("basic_wr_count",  32'(wa_n - wb),        32'd160);
        check("basic_rd_count",  32'(ra_n - rb),        32'd160);
        check("basic_rise",      32'(rise_cyc_a - s),   32'd4);
        check("basic_active",    32'(act_a - ab),       32'd640);
        check("basic_first_wr",  32'(wa_cyc[wb] - s),   32'd5);
        check("basic_last_wr",   32'(wa_cyc[wb + 159] - s), 32'd641);
        for (int i = 0; i < 160; i++) begin
            check($sformatf("basic_addr[%0d]", i), 32'(wa_addr[wb + i]), 32'(i));
            check($sformatf("basic_data[%0d]", i), 32'(wa_data[wb + i]),
                  32'(mem_byte(16'hC100 + 16'(i))));
        end

        // Echo page 0xFE reads 0xDE00..0xDE9F.
        wb = wa_n; rb = ra_n; fb = fall_a;
        pulse_a(8'hFE, s);
        wait_fall_a(fb, "echo_done");
        check("echo_reg_rd",   32'(bus_a.reg_d_rd),   32'h00FE);
        check("echo_rd_count", 32'(ra_n - rb),        32'd160);
        check("echo_first",    32'(ra_addr[rb]),      32'hDE00);
        check("echo_last",     32'(ra_addr[rb + 159]), 32'hDE9F);
        for (int i = 0; i < 160; i++)
            check($sformatf("echo_rd[%0d]", i), 32'(ra_addr[rb + i]), 32'(16'hDE00 + 16'(i)));
        check("echo_data0",    32'(wa_data[wb]),      32'(mem_byte(16'hDE00)));

        // Echo boundary: 0xE0 maps to 0xC0, 0xDF is untouched.
        rb = ra_n; fb = fall_a;
        pulse_a(8'hE0, s);
        wait_fall_a(fb, "e0_done");
        check("e0_first", 32'(ra_addr[rb]), 32'hC000);
        rb = ra_n; fb = fall_a;
        pulse_a(8'hDF, s);
        wait_fall_a(fb, "df_done");
        check("df_first", 32'(ra_addr[rb]), 32'hDF00);

        // Restart at idx=50 ph=1: no partial write, dma_active stays high.
        wb = wa_n; rb = ra_n; ab = act_a; fb = fall_a; rsb = rise_a;
        pulse_a(8'hC0, s);
        wait_rd_a(16'hC032, "restart_reach");
        @(posedge clk); #1;
        bus_a.start    = 1'b1;
        bus_a.src_page = 8'hD0;
        @(negedge clk);
        check("restart_no_write",   32'(bus_a.oam_write),  32'd0);
        check("restart_active_hi",  32'(bus_a.dma_active), 32'd1);
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        wait_fall_a(fb, "restart_done");
        check("restart_rises",    32'(rise_a - rsb), 32'd1);
        check("restart_wr_count", 32'(wa_n - wb),    32'd210);
        check("restart_rd_count", 32'(ra_n - rb),    32'd211);
        check("restart_active",   32'(act_a - ab),   32'd846);
        check("restart_reg_rd",   32'(bus_a.reg_d_rd), 32'h00D0);
        for (int i = 0; i < 50; i++) begin
            check($sformatf("restart_old_addr[%0d]", i), 32'(wa_addr[wb + i]), 32'(i));
            check($sformatf("restart_old_data[%0d]", i), 32'(wa_data[wb + i]),
                  32'(mem_byte(16'hC000 + 16'(i))));
        end
        for (int i = 0; i < 160; i++) begin
            check($sformatf("restart_new_addr[%0d]", i), 32'(wa_addr[wb + 50 + i]), 32'(i));
            check($sformatf("restart_new_data[%0d]", i), 32'(wa_data[wb + 50 + i]),
                  32'(mem_byte(16'hD000 + 16'(i))));
        end

        // Reset at idx=80: outputs drop without a clock, transfer never resumes.
        wb = wa_n;
        pulse_a(8'hC1, s);
        wait_rd_a(16'hC150, "rstmid_reach");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero_a("rstmid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rstmid_wr_count", 32'(wa_n - wb), 32'd80);
        ab = act_a;
        repeat (700) @(negedge clk);
        check("rstmid_no_resume_wr",  32'(wa_n - wb), 32'd80);
        check("rstmid_no_resume_act", 32'(act_a - ab), 32'd0);

        // Minimum divider instance: 4 bytes, 2 clocks per byte.
        wb = wb_n; ab = act_b; fb = fall_b;
        pulse_b(8'h12, s);
        wait_fall_b(fb, "small_done");
        check("small_active",   32'(act_b - ab),      32'd8);
        check("small_rise",     32'(rise_cyc_b - s),  32'd2);
        check("small_wr_count", 32'(wb_n - wb),       32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("small_addr[%0d]", i), 32'(wb_addr[wb + i]), 32'(i));
            check($sformatf("small_data[%0d]", i), 32'(wb_data[wb + i]),
                  32'(mem_byte(16'h1200 + 16'(i))));
            check($sformatf("small_cyc[%0d]", i),  32'(wb_cyc[wb + i] - s), 32'(3 + 2 * i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
